// File: rtl/ped_multi_counter.sv
// NUM_CH independent up/down occupancy counters sharing one runtime limit,
// with rollover/saturate modes, per-channel wrap/underflow pulses and a total.
module ped_multi_counter #(
  parameter int NUM_CH   = 4,
  parameter int CNT_BITS = 6,
  parameter int TOT_BITS = CNT_BITS + $clog2(NUM_CH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [NUM_CH-1:0]          ch_clear,
  input  logic [NUM_CH-1:0]          inc,
  input  logic [NUM_CH-1:0]          dec,
  input  logic                       sat_mode,
  input  logic [CNT_BITS-1:0]        limit,
  output logic [NUM_CH*CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]          r_flag,
  output logic [NUM_CH-1:0]          at_limit,
  output logic [NUM_CH-1:0]          uflow,
  output logic [TOT_BITS-1:0]        total_out,
  output logic                       any_limit
);

  logic [CNT_BITS-1:0] r_cnt [NUM_CH];
  logic [NUM_CH-1:0]   r_wrap;
  logic [NUM_CH-1:0]   r_uflow;

  logic [CNT_BITS-1:0] w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]   w_wrap_nxt;
  logic [NUM_CH-1:0]   w_uflow_nxt;
  logic [TOT_BITS-1:0] w_total;
  logic [NUM_CH-1:0]   w_at_limit;

  // Increments compare against limit before adding, so the counter never
  // wraps internally even when limit is the all-ones value.
  always_comb begin
    w_wrap_nxt  = '0;
    w_uflow_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (clear || ch_clear[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (inc[i] && !dec[i]) begin
        if (r_cnt[i] < limit) begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_BITS'(1);
        end else if (!sat_mode) begin
          w_cnt_nxt[i]  = '0;
          w_wrap_nxt[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = limit;
        end
      end else if (dec[i] && !inc[i]) begin
        if (r_cnt[i] == '0) begin
          w_uflow_nxt[i] = 1'b1;
        end else if (sat_mode && (r_cnt[i] > limit)) begin
          // A zero limit in saturate mode pins the count at zero.
          w_cnt_nxt[i] = (limit == '0) ? '0 : limit - CNT_BITS'(1);
        end else begin
          w_cnt_nxt[i] = r_cnt[i] - CNT_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
      r_wrap  <= '0;
      r_uflow <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_wrap  <= w_wrap_nxt;
      r_uflow <= w_uflow_nxt;
    end
  end

  always_comb begin
    count_out  = '0;
    w_total    = '0;
    w_at_limit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      count_out[i*CNT_BITS +: CNT_BITS] = r_cnt[i];
      w_total       = w_total + TOT_BITS'(r_cnt[i]);
      w_at_limit[i] = (r_cnt[i] >= limit);
    end
  end

  assign r_flag    = r_wrap;
  assign uflow     = r_uflow;
  assign at_limit  = w_at_limit;
  assign any_limit = |w_at_limit;
  assign total_out = w_total;

endmodule

// File: tb/tb_ped_multi_counter.sv
// Bench for ped_multi_counter: directed vector table, hand-written corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_ped_multi_counter;

  localparam int NUM_CH   = 4;
  localparam int CNT_BITS = 6;
  localparam int TOT_BITS = CNT_BITS + $clog2(NUM_CH) + 1;

  logic                       clk;
  logic                       rst;
  logic                       clear;
  logic [NUM_CH-1:0]          ch_clear;
  logic [NUM_CH-1:0]          inc;
  logic [NUM_CH-1:0]          dec;
  logic                       sat_mode;
  logic [CNT_BITS-1:0]        limit;
  logic [NUM_CH*CNT_BITS-1:0] count_out;
  logic [NUM_CH-1:0]          r_flag;
  logic [NUM_CH-1:0]          at_limit;
  logic [NUM_CH-1:0]          uflow;
  logic [TOT_BITS-1:0]        total_out;
  logic                       any_limit;

  ped_multi_counter #(.NUM_CH(NUM_CH), .CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .rst(rst), .clear(clear), .ch_clear(ch_clear),
    .inc(inc), .dec(dec), .sat_mode(sat_mode), .limit(limit),
    .count_out(count_out), .r_flag(r_flag), .at_limit(at_limit),
    .uflow(uflow), .total_out(total_out), .any_limit(any_limit)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_cnt [NUM_CH];
  bit m_rf  [NUM_CH];
  bit m_uf  [NUM_CH];

  typedef struct {
    logic                       clr;
    logic [NUM_CH-1:0]          chc;
    logic [NUM_CH-1:0]          inc;
    logic [NUM_CH-1:0]          dec;
    logic                       sat;
    logic [CNT_BITS-1:0]        lim;
    logic [NUM_CH*CNT_BITS-1:0] exp_cnt;
    logic [TOT_BITS-1:0]        exp_tot;
    logic [NUM_CH-1:0]          exp_rf;
    logic [NUM_CH-1:0]          exp_uf;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [NUM_CH*CNT_BITS-1:0] pack4(int c0, int c1, int c2, int c3);
    logic [NUM_CH*CNT_BITS-1:0] v;
    v = '0;
    v[0*CNT_BITS +: CNT_BITS] = CNT_BITS'(c0);
    v[1*CNT_BITS +: CNT_BITS] = CNT_BITS'(c1);
    v[2*CNT_BITS +: CNT_BITS] = CNT_BITS'(c2);
    v[3*CNT_BITS +: CNT_BITS] = CNT_BITS'(c3);
    return v;
  endfunction

  // Reference rules expressed on plain integers, applied to the inputs
  // presented for the coming edge.
  function automatic void model_step();
    int lim_i;
    lim_i = int'(limit);
    for (int i = 0; i < NUM_CH; i++) begin
      m_rf[i] = 1'b0;
      m_uf[i] = 1'b0;
      if (rst || clear || ch_clear[i]) begin
        m_cnt[i] = 0;
      end else if (inc[i] && !dec[i]) begin
        if (m_cnt[i] < lim_i) m_cnt[i] = m_cnt[i] + 1;
        else if (!sat_mode) begin m_cnt[i] = 0; m_rf[i] = 1'b1; end
        else m_cnt[i] = lim_i;
      end else if (dec[i] && !inc[i]) begin
        if (m_cnt[i] == 0) m_uf[i] = 1'b1;
        else if (sat_mode && m_cnt[i] > lim_i) m_cnt[i] = (lim_i == 0) ? 0 : lim_i - 1;
        else m_cnt[i] = m_cnt[i] - 1;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply current inputs across one rising edge, then settle
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [NUM_CH*CNT_BITS-1:0] e_cnt;
    logic [NUM_CH-1:0] e_rf, e_uf, e_al;
    int tot;
    e_cnt = '0; e_rf = '0; e_uf = '0; e_al = '0; tot = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      e_cnt[i*CNT_BITS +: CNT_BITS] = CNT_BITS'(m_cnt[i]);
      e_rf[i] = m_rf[i];
      e_uf[i] = m_uf[i];
      e_al[i] = (m_cnt[i] >= int'(limit));
      tot += m_cnt[i];
    end
    chk({tag, ".count"}, 64'(count_out), 64'(e_cnt));
    chk({tag, ".total"}, 64'(total_out), 64'(tot));
    chk({tag, ".r_flag"}, 64'(r_flag), 64'(e_rf));
    chk({tag, ".uflow"}, 64'(uflow), 64'(e_uf));
    chk({tag, ".at_limit"}, 64'(at_limit), 64'(e_al));
    chk({tag, ".any_limit"}, 64'(any_limit), 64'(|e_al));
  endtask

  task automatic idle_inputs();
    clear = 1'b0; ch_clear = '0; inc = '0; dec = '0;
  endtask

  initial begin
    rst = 1'b1; idle_inputs(); sat_mode = 1'b0; limit = 6'd50;
    inc = '1;
    tick(); tick();
    chk("rst.count", 64'(count_out), 64'd0);
    chk("rst.total", 64'(total_out), 64'd0);
    chk("rst.at_limit", 64'(at_limit), 64'd0);
    chk("rst.flags", 64'({r_flag, uflow}), 64'd0);
    limit = 6'd0;
    #1;
    chk("rst.at_limit_lim0", 64'(at_limit), 64'hF);
    chk("rst.any_limit_lim0", 64'(any_limit), 64'd1);
    limit = 6'd50;
    rst = 1'b0; inc = '0;

    // directed vectors: clr, chc, inc, dec, sat, lim, exp_cnt, exp_tot, exp_rf, exp_uf
    tbl[0]  = '{1'b0, 4'h0, 4'h1, 4'h0, 1'b0, 6'd50, pack4(1,0,0,0), 9'd1, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 4'h0, 4'h1, 4'h0, 1'b0, 6'd50, pack4(2,0,0,0), 9'd2, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 4'h0, 4'h1, 4'h0, 1'b0, 6'd50, pack4(3,0,0,0), 9'd3, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 4'h0, 4'h1, 4'h1, 1'b0, 6'd50, pack4(3,0,0,0), 9'd3, 4'h0, 4'h0};
    tbl[4]  = '{1'b0, 4'h0, 4'h0, 4'h8, 1'b0, 6'd50, pack4(3,0,0,0), 9'd3, 4'h0, 4'h8};
    tbl[5]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 6'd50, pack4(3,0,0,0), 9'd3, 4'h0, 4'h0};
    tbl[6]  = '{1'b0, 4'h0, 4'h6, 4'h0, 1'b0, 6'd50, pack4(3,1,1,0), 9'd5, 4'h0, 4'h0};
    tbl[7]  = '{1'b0, 4'h2, 4'h3, 4'h0, 1'b0, 6'd50, pack4(4,0,1,0), 9'd5, 4'h0, 4'h0};
    tbl[8]  = '{1'b1, 4'h0, 4'hF, 4'h0, 1'b0, 6'd50, pack4(0,0,0,0), 9'd0, 4'h0, 4'h0};
    tbl[9]  = '{1'b0, 4'h0, 4'h1, 4'h0, 1'b0, 6'd0,  pack4(0,0,0,0), 9'd0, 4'h1, 4'h0};
    tbl[10] = '{1'b0, 4'h0, 4'h1, 4'h0, 1'b1, 6'd0,  pack4(0,0,0,0), 9'd0, 4'h0, 4'h0};
    for (int k = 0; k < 11; k++) begin
      clear = tbl[k].clr; ch_clear = tbl[k].chc; inc = tbl[k].inc;
      dec = tbl[k].dec; sat_mode = tbl[k].sat; limit = tbl[k].lim;
      tick();
      chk($sformatf("vec%0d.count", k), 64'(count_out), 64'(tbl[k].exp_cnt));
      chk($sformatf("vec%0d.total", k), 64'(total_out), 64'(tbl[k].exp_tot));
      chk($sformatf("vec%0d.r_flag", k), 64'(r_flag), 64'(tbl[k].exp_rf));
      chk($sformatf("vec%0d.uflow", k), 64'(uflow), 64'(tbl[k].exp_uf));
    end

    // rollover on ch1 at limit 50
    idle_inputs(); sat_mode = 1'b0; limit = 6'd50;
    inc = 4'h2;
    for (int k = 1; k <= 51; k++) begin
      tick();
      check_model($sformatf("roll%0d", k));
      if (k == 50) chk("roll.at_limit50", 64'(at_limit[1]), 64'd1);
    end
    chk("roll.wrap_count", 64'(count_out[1*CNT_BITS +: CNT_BITS]), 64'd0);
    chk("roll.wrap_flag", 64'(r_flag[1]), 64'd1);
    inc = '0;
    tick();
    chk("roll.flag_drops", 64'(r_flag[1]), 64'd0);

    // saturate on ch2, then lower the limit under it
    sat_mode = 1'b1; inc = 4'h4;
    for (int k = 1; k <= 60; k++) begin
      tick();
      check_model($sformatf("sat%0d", k));
    end
    chk("sat.hold50", 64'(count_out[2*CNT_BITS +: CNT_BITS]), 64'd50);
    limit = 6'd40; tick();
    chk("sat.clamp40", 64'(count_out[2*CNT_BITS +: CNT_BITS]), 64'd40);
    inc = '0; dec = 4'h4; tick();
    chk("sat.dec39", 64'(count_out[2*CNT_BITS +: CNT_BITS]), 64'd39);
    check_model("sat.after");

    // mid-operation reset suppresses a pending underflow pulse
    idle_inputs(); sat_mode = 1'b0; limit = 6'd50;
    inc = 4'h7; tick(); tick();
    inc = 4'h7; dec = 4'h8; rst = 1'b1; tick();
    check_model("midrst");
    chk("midrst.uflow", 64'(uflow), 64'd0);
    rst = 1'b0; idle_inputs();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 99) == 0);
      clear    = ($urandom_range(0, 49) == 0);
      ch_clear = ($urandom_range(0, 9) == 0) ? NUM_CH'($urandom) : '0;
      inc      = NUM_CH'($urandom);
      dec      = NUM_CH'($urandom) & NUM_CH'($urandom);
      if ($urandom_range(0, 19) == 0) sat_mode = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 4))
          0: limit = 6'd0;
          1: limit = 6'd1;
          2: limit = 6'd63;
          3: limit = 6'd50;
          default: limit = CNT_BITS'($urandom_range(0, 63));
        endcase
      end
      tick();
      check_model($sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ped_multi_counter.md
Name: ped_multi_counter

Overview:
Parametrised multi-channel successor to the single-channel pedestrian counter. It keeps NUM_CH independent up/down occupancy counters, one per crossing or entrance, all sharing a runtime-programmable limit. Each counter either rolls over or saturates at the limit, selected at runtime. The block produces per-channel wrap/limit flags and an aggregate occupancy total for the controller FSM.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
CNT_BITS, 6, width of each channel counter
TOT_BITS, CNT_BITS+$clog2(NUM_CH)+1, width of aggregate total (never overflows)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
clear  input  1  synchronous clear of all channels
ch_clear  input  NUM_CH  per-channel synchronous clear
inc  input  NUM_CH  per-channel count-up enable, one per cycle
dec  input  NUM_CH  per-channel count-down enable, one per cycle
sat_mode  input  1  0 = rollover mode, 1 = saturate mode
limit  input  CNT_BITS  shared limit value (default use 50)
count_out  output  NUM_CH*CNT_BITS  channel i at bits [i*CNT_BITS +: CNT_BITS]
r_flag  output  NUM_CH  one-cycle pulse per channel on wrap (rollover mode only)
at_limit  output  NUM_CH  level: count_out[i] >= limit
uflow  output  NUM_CH  one-cycle pulse when dec is attempted at count 0
total_out  output  TOT_BITS  sum of all channel counts
any_limit  output  1  OR of at_limit

Behaviour:
- Reset (rst=1 at clk edge): all counts = 0, r_flag = 0, uflow = 0. total_out, at_limit and any_limit follow, so total_out = 0 and at_limit = 0, except when limit = 0, where at_limit = all ones. rst overrides everything.
- Priority per channel, per edge: rst > clear | ch_clear[i] > count update.
  - A clear forces count 0 and r_flag[i] = uflow[i] = 0 in that cycle. It discards any inc/dec presented in the same cycle.
- Count update, channel i:
  - inc=1, dec=1: no change, no flags.
  - inc=1, dec=0, count < limit: count+1.
  - inc=1, dec=0, count >= limit, rollover mode: count becomes 0 and r_flag[i] = 1 for the next cycle.
    - This covers count above limit after limit was lowered at runtime.
  - inc=1, dec=0, count >= limit, saturate mode: count becomes limit (clamps down if above), no r_flag.
  - dec=1, inc=0, count > 0: count-1. If count > limit in saturate mode, clamp to limit-1 instead.
  - dec=1, inc=0, count == 0: count stays 0 in both modes, and uflow[i] = 1 for the next cycle.
  - Neither asserted: hold.
- r_flag and uflow are registered pulses, high exactly one cycle after the causing edge, unless re-triggered.
- limit = 0:
  - Rollover mode: every inc pulses r_flag and leaves count 0.
  - Saturate mode: count held at 0.
- Arithmetic:
  - total_out is the combinational zero-extended sum of the registered counts, valid in the same cycle as count_out.
  - at_limit and any_limit are combinational from registered counts and the current limit.
  - No internal wrap: counts never exceed 2^CNT_BITS-1. Increments are compared against limit before +1, so limit = 2^CNT_BITS-1 wraps cleanly.
- sat_mode and limit may change any cycle; they take effect at the next edge. Existing counts are not modified until that channel's next inc/dec.
- Channels are fully independent; simultaneous events on different channels do not interact.

Test Plan:
- rst=1 for 2 cycles with inc all high, then release with limit=50 -> all count_out 0, total_out 0, flags 0. Then 3 incs on ch0 -> ch0=3, total_out=3.
- Rollover: limit=50, sat_mode=0, ch1 inc 51 cycles -> ch1 reaches 50 at cycle 50. At cycle 51 it reads 0 with r_flag[1]=1 for exactly one cycle; at_limit[1] high only while ch1=50.
- Saturate: sat_mode=1, ch2 inc 60 cycles -> ch2 holds 50, r_flag[2] never set. Then lower limit to 40 and inc -> ch2=40. Then dec -> 39.
- Underflow and simultaneity: ch3 at 0 with dec -> stays 0, uflow[3] pulses one cycle. inc&dec together on ch0=3 -> stays 3.
- Clear priority: ch0=5, ch1=7, ch_clear[1]=1 with inc[1]=1, inc[0]=1 -> ch0=6, ch1=0, total_out=6. Global clear -> all 0 next cycle.
- Mid-operation rst: four channels counting, assert rst for 1 cycle -> all counts 0 the next cycle, pending r_flag/uflow pulses suppressed.
